regfile_dump_reader: RTL and testbench
======================================

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of registers dumped (legal 2..32).
REQ-002 SHALL have clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have start  input  1  one-cycle request to begin a dump.
REQ-005 SHALL have abort  input  1  terminate the dump in progress.
REQ-006 SHALL have rf_addr  output  5  register-file read index, driven to a register-file read-port select.
REQ-007 SHALL have rf_data  input  32  combinational read data for rf_addr, with x0 reading as 0.
REQ-008 SHALL have out_valid  output  1  out_data/out_index valid.
REQ-009 SHALL have out_ready  input  1  consumer accepts the word when out_valid is also 1.
REQ-010 SHALL have out_data  output  32  captured register value.
REQ-011 SHALL have out_index  output  5  register index of out_data.
REQ-012 SHALL have busy  output  1  high in every state except IDLE.
REQ-013 SHALL have done  output  1  one-cycle pulse after the last word is accepted.
REQ-014 SHALL have checksum  output  32  XOR of all accepted words, held stable from the done pulse until the next start.

Function
REQ-015 SHALL implement the states IDLE, FETCH, HOLD and FIN.
REQ-016 In IDLE, start=1 and abort=0 SHALL load idx with the first index (0), clear checksum, and move to FETCH.
REQ-017 In FETCH, rf_addr SHALL equal idx, and rf_data SHALL be registered into out_data, with idx registered into out_index, at the end of the cycle; next state HOLD.
REQ-018 In HOLD, out_valid SHALL be 1, and out_data and out_index SHALL be held stable until out_valid&out_ready.
REQ-019 On out_valid&out_ready in HOLD, checksum SHALL become checksum^out_data.
REQ-020 On that same cycle, if idx==NUM_REGS-1 the state SHALL go to FIN; otherwise idx SHALL increment by 1 and the state SHALL go to FETCH.
REQ-021 FIN SHALL assert done for exactly one cycle, then go to IDLE.
REQ-022 Latency from start sampled at cycle N SHALL be: first out_valid at N+2; with out_ready held at 1, one word every 2 cycles.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort in FETCH, HOLD or FIN SHALL go to IDLE next cycle with out_valid=0, no done pulse, and no checksum update for a word in HOLD.
REQ-025 abort together with start in IDLE SHALL win: the block stays in IDLE.
REQ-026 rf_addr SHALL be 0 when the state is not FETCH.
REQ-027 Each word SHALL be sampled only in its own FETCH cycle; register-file writes occurring mid-dump are visible for not-yet-fetched indices, so there is no atomic snapshot.
REQ-028 idx SHALL be 5 bits and SHALL never wrap past NUM_REGS-1.

Reset
REQ-029 While rst_n=0, the state SHALL be IDLE, with idx, out_data, out_index and checksum at 0, and out_valid, busy and done at 0.
REQ-030 Reset asserted mid-dump SHALL abandon the dump immediately (asynchronously), with no done pulse.

Configuration
REQ-031 Macro DUMP_SKIP_X0_EN SHALL control handling of x0.
REQ-032 With DUMP_SKIP_X0_EN defined, the first index SHALL be 1 and NUM_REGS-1 words SHALL be emitted.
REQ-033 Without DUMP_SKIP_X0_EN, the first index SHALL be 0 and NUM_REGS words SHALL be emitted, the first with out_index=0 and out_data=0.

Verification
REQ-034 Regfile preloaded xi=i*0x01010101, start, out_ready=1 -> 32 words with index 0..31 in order, done at cycle start+65, checksum=XOR of all words (0x00000000).
REQ-035 out_ready held low 5 cycles on index 3 -> out_data=0x03030303 and out_index=3 stable throughout, no skipped or duplicated index.
REQ-036 abort while HOLD on index 10 -> out_valid=0 next cycle, busy=0, no done; a new start restarts from index 0.
REQ-037 start pulsed again at index 5 -> ignored, dump completes normally with 32 words.
REQ-038 rst_n low while on index 7 -> all outputs 0 immediately, state IDLE, no done.
REQ-039 DUMP_SKIP_X0_EN defined, NUM_REGS=4 -> words with index 1,2,3 only, done after the third accepted word.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Streams register-file contents out one word at a time with a running XOR checksum.
// Build option: define DUMP_SKIP_X0_EN to start the dump at x1 instead of x0.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FIN
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
`ifdef DUMP_SKIP_X0_EN
  localparam logic [4:0] FIRST_IDX = 5'd1;
`else
  localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  index_q, index_d;
  logic [31:0] chk_q, chk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      index_q <= index_d;
      chk_q   <= chk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    index_d   = index_q;
    chk_d     = chk_q;
    rf_addr   = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          idx_d   = FIRST_IDX;
          chk_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rf_addr = idx_q;
        if (abort) begin
          state_d = IDLE;
        end else begin
          data_d  = rf_data;
          index_d = idx_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          chk_d = chk_q ^ data_q;
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = FETCH;
          end
        end
      end
      FIN: begin
        // an abort landing on the final cycle suppresses the pulse
        done    = !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data  = data_q;
  assign out_index = index_q;
  assign checksum  = chk_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: per-cycle check against a
// transaction-level model plus directed literal checks.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 32;
`ifdef DUMP_SKIP_X0_EN
  localparam int FIRST    = 1;
  localparam int DONE_LAT = 63;
`else
  localparam int FIRST    = 0;
  localparam int DONE_LAT = 65;
`endif
  localparam int NWORDS = NUM_REGS - FIRST;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] rf_mem [32];

  regfile_dump_reader #(.NUM_REGS(NUM_REGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  assign rf_data = (rf_addr == 5'd0) ? 32'd0 : rf_mem[rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at t=%0t", nm, $time);
  endtask

  // Model: a dump is a list of words; word k may only be presented
  // once it has been fetched, and is retired by a handshake.
  int          cyc = 0;
  bit          m_active = 0;
  logic [4:0]  m_next = '0;
  int          m_vcyc = 0;
  int          m_fin = -1;
  logic [31:0] m_word = '0;
  logic [31:0] m_chk = '0;

  function automatic logic [31:0] rf_word(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : rf_mem[i];
  endfunction

  initial begin : model
    bit pv, pbusy;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0;
        m_fin    = -1;
        m_chk    = '0;
      end else begin
        pv    = m_active && (cyc >= m_vcyc);
        pbusy = m_active || (cyc == m_fin);
        if (m_active && cyc == m_vcyc - 1) m_word = rf_word(m_next);
        cyc++;
        if (m_active) begin
          if (abort) begin
            m_active = 0;
          end else if (pv && out_ready) begin
            m_chk = m_chk ^ m_word;
            if (int'(m_next) == NUM_REGS - 1) begin
              m_active = 0;
              m_fin    = cyc;
            end else begin
              m_next = m_next + 5'd1;
              m_vcyc = cyc + 1;
            end
          end
        end else if (!pbusy && start && !abort) begin
          m_active = 1;
          m_next   = 5'(FIRST);
          m_vcyc   = cyc + 1;
          m_chk    = '0;
        end
      end
    end
  end

  int acc_seen  = 0;
  int done_seen = 0;

  initial begin : compare
    bit ev, ef, eb, ed;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_index", {27'd0, out_index}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
      end else begin
        ev = m_active && (cyc >= m_vcyc);
        ef = m_active && (cyc == m_vcyc - 1);
        eb = m_active || (cyc == m_fin);
        ed = (cyc == m_fin) && !abort;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("busy", {31'd0, busy}, {31'd0, eb});
        chk("done", {31'd0, done}, {31'd0, ed});
        chk("checksum", checksum, m_chk);
        chk("rf_addr", {27'd0, rf_addr}, ef ? {27'd0, m_next} : 32'd0);
        if (ev) begin
          chk("out_index", {27'd0, out_index}, {27'd0, m_next});
          chk("out_data", out_data, m_word);
        end
        if (out_valid && out_ready && !abort) acc_seen++;
        if (done) done_seen++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int d, output bit ok);
    ok = 0;
    d = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        d = cyc;
      end
    end
    if (!ok) timeout(nm);
  endtask

  task automatic wait_idx(input string nm, input int idx, output bit ok);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      step();
      if (out_valid && int'(out_index) == idx) ok = 1;
    end
    if (!ok) timeout(nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int s, d, base, dbase;
    bit ok;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h01010101;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // full dump at full rate
    base = acc_seen;
    pulse_start(s);
    wait_done("full_done", d, ok);
    if (ok) begin
      chk("full_latency", 32'(d - s), 32'(DONE_LAT));
      chk("full_checksum", checksum, 32'h00000000);
      chk("full_words", 32'(acc_seen - base), 32'(NWORDS));
    end
    step();
    step();
    chk("checksum_held", checksum, 32'h00000000);

    // back-pressure on index 3
    base = acc_seen;
    pulse_start(s);
    step();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_index", {27'd0, out_index}, 32'(FIRST));
    wait_idx("stall_idx3", 3, ok);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_data", out_data, 32'h03030303);
      chk("stall_index", {27'd0, out_index}, 32'd3);
      step();
    end
    out_ready = 1'b1;
    wait_done("stall_done", d, ok);
    if (ok) chk("stall_words", 32'(acc_seen - base), 32'(NWORDS));
    step();

    // abort while holding index 10, then restart
    dbase = done_seen;
    pulse_start(s);
    wait_idx("abort_idx10", 10, ok);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) step();
    chk("abort_nodone", 32'(done_seen - dbase), 32'd0);
    base = acc_seen;
    pulse_start(s);
    step();
    chk("restart_index", {27'd0, out_index}, 32'(FIRST));
    wait_done("restart_done", d, ok);
    if (ok) chk("restart_words", 32'(acc_seen - base), 32'(NWORDS));
    step();

    // second start mid-dump, plus a regfile write ahead of the fetch
    base = acc_seen;
    pulse_start(s);
    wait_idx("restart_idx5", 5, ok);
    start = 1'b1;
    rf_mem[20] = 32'hA5A5A5A5;
    step();
    start = 1'b0;
    wait_done("dup_done", d, ok);
    if (ok) begin
      chk("dup_words", 32'(acc_seen - base), 32'(NWORDS));
      chk("dup_checksum", checksum, 32'hB1B1B1B1);
      chk("dup_latency", 32'(d - s), 32'(DONE_LAT));
    end
    rf_mem[20] = 32'h14141414;
    step();

    // asynchronous reset on index 7
    dbase = done_seen;
    pulse_start(s);
    wait_idx("reset_idx7", 7, ok);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_index", {27'd0, out_index}, 32'd0);
    chk("arst_checksum", checksum, 32'd0);
    chk("arst_addr", {27'd0, rf_addr}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("arst_nodone", 32'(done_seen - dbase), 32'd0);
    chk("arst_idle", {31'd0, busy}, 32'd0);

    base = acc_seen;
    pulse_start(s);
    wait_done("post_reset_done", d, ok);
    if (ok) begin
      chk("post_reset_words", 32'(acc_seen - base), 32'(NWORDS));
      chk("post_reset_checksum", checksum, 32'h00000000);
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
